// File: rtl/systolic_input_skewer.sv
// Operand skewer for one systolic-array edge: lane i is delayed by i extra cycles and
// zeros fill every non-data slot. Optional bubble counter under SKEW_BUBBLE_COUNT_EN.
module systolic_input_skewer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N          = 4,
    parameter int unsigned K_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [K_WIDTH-1:0]      k_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_data,
    output logic [N*DATA_WIDTH-1:0] out_data,
    output logic                    busy,
    output logic                    done
`ifdef SKEW_BUBBLE_COUNT_EN
    ,
    output logic [15:0]             bubble_count
`endif
);

    localparam int unsigned FW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [K_WIDTH-1:0] rem_q, rem_d;
    logic [FW-1:0]      fcnt_q, fcnt_d;
    logic               accept;

    assign accept   = (state_q == S_STREAM) && in_valid;
    assign in_ready = (state_q == S_STREAM);
    assign busy     = (state_q == S_STREAM) || (state_q == S_FLUSH);
    assign done     = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d   = k_len;
                    state_d = (k_len != '0) ? S_STREAM : S_DONE;
                end
            end
            S_STREAM: begin
                if (in_valid) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == K_WIDTH'(1)) begin
                        state_d = S_FLUSH;
                        fcnt_d  = '0;
                    end
                end
            end
            S_FLUSH: begin
                // N flush cycles let the deepest lane drain its last element.
                if (fcnt_q == FW'(N - 1)) begin
                    state_d = S_DONE;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            fcnt_q  <= fcnt_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] sr_q [0:i];
        logic [DATA_WIDTH-1:0] lane_in;

        assign lane_in = accept ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;

        always_ff @(posedge clk) begin
            if (rst) begin
                sr_q[0] <= '0;
            end else begin
                sr_q[0] <= lane_in;
            end
        end

        for (genvar j = 1; j <= i; j++) begin : g_stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    sr_q[j] <= '0;
                end else begin
                    sr_q[j] <= sr_q[j-1];
                end
            end
        end

        assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = sr_q[i];
    end

`ifdef SKEW_BUBBLE_COUNT_EN
    logic [15:0] bub_q, bub_d;

    always_comb begin
        bub_d = bub_q;
        if ((state_q == S_IDLE) && start) begin
            bub_d = '0;
        end else if ((state_q == S_STREAM) && !in_valid && (bub_q != '1)) begin
            bub_d = bub_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bub_q <= '0;
        end else begin
            bub_q <= bub_d;
        end
    end

    assign bubble_count = bub_q;
`endif

endmodule

// File: doc/systolic_input_skewer.md
Name: systolic_input_skewer

Overview:
- Feeder stage directly upstream of the PE grid's west (or north) edge.
- Accepts one N-element operand vector per cycle from the operand buffer. Delays lane i by i cycles, so the grid sees the diagonal wavefront it needs to form dot products.
- Injects zeros on bubbles and during drain, so PE accumulators only ever add 0 outside valid data.
- One instance is used for the A edge and one for the B edge.

Parameters:
- DATA_WIDTH, 8, width of one operand element.
- N, 4, number of lanes (grid rows or columns); N >= 2.
- K_WIDTH, 8, width of the vector-count field k_len.

Ports:
- clk  input  1  clock.
- rst  input  1  reset. Synchronous, active-high; sampled on the rising edge of clk.
- start  input  1  one-cycle pulse; begins a frame; honoured only in IDLE.
- k_len  input  K_WIDTH  number of vectors in the frame; latched on start.
- in_valid  input  1  in_data holds a valid vector.
- in_ready  output  1  skewer accepts a vector this cycle.
- in_data  input  N*DATA_WIDTH  lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_data  output  N*DATA_WIDTH  skewed lanes to the grid edge; same packing as in_data.
- busy  output  1  high in STREAM and FLUSH.
- done  output  1  one-cycle pulse at the end of the frame.

Behaviour:
- Reset:
  - State goes to IDLE; all delay registers, out_data, in_ready, busy and done go to 0; the remaining-vector counter clears.
  - Reset mid-frame aborts the frame immediately. No done is issued. The first out_data value after reset is 0.
- State machine: IDLE -> STREAM -> FLUSH -> DONE -> IDLE.
  - IDLE: start=1 latches k_len into the remaining counter.
    - k_len != 0: go to STREAM.
    - k_len == 0: go straight to DONE (no data, no flush).
    - start outside IDLE is ignored.
  - STREAM: in_ready=1. A vector is accepted when in_valid && in_ready; each accept decrements the counter. When the accept makes the counter 0, go to FLUSH on the next edge.
  - FLUSH: in_ready=0, lane-0 input forced to zero. Lasts exactly N cycles, counted by an internal flush counter, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Delay and injection:
  - Lane i passes through i+1 registers: one input stage plus i skew stages.
  - A vector accepted at rising edge t drives out_data lane i during the cycle after edge t+i, i.e. lane 0 is visible one cycle after acceptance.
  - Zero injection: in STREAM with in_valid=0 (bubble), in FLUSH, in DONE and in IDLE, the value entering every lane's input stage is 0. Bubbles therefore stay aligned across all lanes.
- Delay registers shift every cycle unconditionally; there is no back-pressure from the grid.
- No arithmetic is performed; data passes through bit-exact.
- Simultaneous events:
  - rst has priority over start and in_valid.
  - in_valid asserted in FLUSH, DONE or IDLE is not accepted (in_ready=0) and the data is discarded.
- After DONE, out_data is all zeros: the last nonzero lane-(N-1) element appears in the final FLUSH cycle.

Optional Feature:
- Macro: SKEW_BUBBLE_COUNT_EN.
- Defined:
  - Adds output port bubble_count, 16 bits. It counts STREAM cycles with in_valid=0.
  - Clears on start and on rst; saturates at 16'hFFFF.
  - Holds its value after done until the next start.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
1. N=4, DATA_WIDTH=8, k_len=3, vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12} on consecutive cycles from start+1 -> lane0 shows 1,5,9; lane3 shows 4,8,12 exactly three cycles later than lane0. FLUSH lasts 4 cycles, done pulses once, then out_data=0.
2. k_len=2 with one in_valid=0 cycle between vectors -> every lane shows a single 0 between its two elements, at the same relative offset. With SKEW_BUBBLE_COUNT_EN, bubble_count=1.
3. start with k_len=0 -> done pulses on the cycle after start, busy never rises, out_data stays 0.
4. rst asserted on the second STREAM cycle of a k_len=4 frame -> next cycle all outputs are 0, state IDLE, no done. A new start with k_len=1 then completes normally.
5. start pulsed during FLUSH, plus in_valid=1 during FLUSH with data 8'hFF -> start ignored and 8'hFF never appears on out_data; frame ends with a single done.
6. Back-to-back frames: start asserted on the cycle after done -> second frame is accepted with no extra idle cycle, and lane alignment is correct for both frames.
